// File: rtl/bitbang_link.sv
// bitbang_link: bit-banged host link slave receiving work units and returning queued result words
module bitbang_link #(
    parameter int WORK_BYTES   = 64,
    parameter int RESULT_BYTES = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic                        rxd,
    input  logic                        rxc,
    input  logic                        rxtxr,
    input  logic                        txc,
    output logic                        txd,
    output logic [WORK_BYTES*8-1:0]     work_data,
    output logic                        work_valid,
    input  logic [RESULT_BYTES*8-1:0]   result_data,
    input  logic                        result_push,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  drop_count,
    output logic                        rx_busy
);
    localparam int WW  = WORK_BYTES * 8;
    localparam int RW  = RESULT_BYTES * 8;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BCW = $clog2(WORK_BYTES + 1);
    localparam int RBW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
    localparam int SW  = $clog2(RW);

    typedef enum logic {IDLE, DATA} tx_state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [2:0]     prev_q, prev_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [6:0]     bytesh_q, bytesh_d;
    logic [WW-9:0]  worksh_q, worksh_d;
    logic [WW-1:0]  work_data_q, work_data_d;
    logic           work_valid_q, work_valid_d;
    logic [RW-1:0]  mem_q [FIFO_DEPTH];
    logic [RW-1:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     drop_q, drop_d;
    tx_state_t      state_q, state_d;
    logic [RBW-1:0] byte_idx_q, byte_idx_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic           txd_q, txd_d;
    logic [3:0]     s;
    logic           rxc_e, rs_e, txc_e, full, pop, push_ok;
    logic [7:0]     rx_byte;
    logic [WW-1:0]  work_next;
    logic [SW-1:0]  tx_sel;

    // last synchroniser stage holds {txc, rxtxr, rxc, rxd}
    assign s     = sync_q[SYNC_STAGES-1];
    assign rxc_e = s[1] & ~prev_q[0];
    assign rs_e  = s[2] & ~prev_q[1];
    assign txc_e = s[3] & ~prev_q[2];

    assign txd        = txd_q;
    assign work_data  = work_data_q;
    assign work_valid = work_valid_q;
    assign fifo_count = count_q;
    assign drop_count = drop_q;
    assign rx_busy    = (bit_cnt_q != '0) || (byte_cnt_q != '0);

    // next state for synchronisers, RX deserialiser, TX marker FSM and result FIFO; resync overrides both strobes
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], {txc, rxtxr, rxc, rxd}};
        prev_d       = s[3:1];
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        bytesh_d     = bytesh_q;
        worksh_d     = worksh_q;
        work_data_d  = work_data_q;
        work_valid_d = 1'b0;
        rx_byte      = {s[0], bytesh_q};
        work_next    = {worksh_q, rx_byte};
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        txd_d        = txd_q;
        pop          = 1'b0;
        tx_sel       = SW'(8 * (RESULT_BYTES - 1 - int'(byte_idx_q)) + int'(bit_idx_q));
        if (rs_e) begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            state_d    = IDLE;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            txd_d      = 1'b0;
        end else begin
            if (rxc_e) begin
                bytesh_d  = rx_byte[7:1];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    worksh_d   = work_next[WW-9:0];
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q == BCW'(WORK_BYTES - 1)) begin
                        work_data_d  = work_next;
                        work_valid_d = 1'b1;
                        byte_cnt_d   = '0;
                    end
                end
            end
            if (txc_e) begin
                if (state_q == IDLE) begin
                    txd_d = count_q != '0;
                    if (count_q != '0) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    txd_d     = mem_q[rd_ptr_q][tx_sel];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = IDLE;
                        byte_idx_d = byte_idx_q + RBW'(1);
                        if (byte_idx_q == RBW'(RESULT_BYTES - 1)) begin
                            byte_idx_d = '0;
                            pop        = 1'b1;
                        end
                    end
                end
            end
        end
        full     = count_q == CW'(FIFO_DEPTH);
        push_ok  = result_push & (~full | pop);
        mem_d    = mem_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        drop_d   = (result_push && !push_ok && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
        if (push_ok) mem_d[wr_ptr_q] = result_data;
    end

    // all state registers, cleared by asynchronous active-low reset
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev_q       <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            bytesh_q     <= '0;
            worksh_q     <= '0;
            work_data_q  <= '0;
            work_valid_q <= 1'b0;
            mem_q        <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            drop_q       <= '0;
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            txd_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            bytesh_q     <= bytesh_d;
            worksh_q     <= worksh_d;
            work_data_q  <= work_data_d;
            work_valid_q <= work_valid_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            txd_q        <= txd_d;
        end
    end
endmodule

// File: tb/tb_bitbang_link.sv
// tb_bitbang_link: scoreboard bench driving the host protocol against a queue-based link model
module tb_bitbang_link;
    localparam int WB = 64;
    localparam int RB = 4;
    localparam int FD = 4;

    logic sysclk = 1'b0;
    logic rst_n, rxd, rxc, rxtxr, txc, txd, work_valid, result_push, rx_busy;
    logic [WB*8-1:0] work_data;
    logic [RB*8-1:0] result_data;
    logic [2:0] fifo_count;
    logic [7:0] drop_count;

    int tests = 0, fails = 0, wv_seen = 0, frames = 0, drops = 0;
    logic [511:0] exp_work[$];
    logic [31:0]  model[$];
    logic [7:0]   exp_bytes[$];
    logic [7:0]   got_q[$];
    bit           wv_prev;

    always #5 sysclk = ~sysclk;

    bitbang_link #(.WORK_BYTES(WB), .RESULT_BYTES(RB), .FIFO_DEPTH(FD), .SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .rxd(rxd), .rxc(rxc), .rxtxr(rxtxr), .txc(txc), .txd(txd),
        .work_data(work_data), .work_valid(work_valid), .result_data(result_data),
        .result_push(result_push), .fifo_count(fifo_count), .drop_count(drop_count), .rx_busy(rx_busy)
    );

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // monitor: pops expected work units and result bytes whenever the DUT presents them
    initial forever begin
        @(negedge sysclk);
        if (!rst_n) wv_prev = 1'b0;
        else begin
            if (wv_prev) check("work_valid_one_cycle", work_valid, 0);
            if (work_valid) begin
                wv_seen++;
                if (exp_work.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_work_valid: got data %0h expected no commit", work_data);
                end else check("work_data", work_data, exp_work.pop_front());
            end
            wv_prev = work_valid;
        end
        while (got_q.size() > 0) begin
            if (exp_bytes.size() == 0) begin
                tests++; fails++;
                $display("FAIL tx_byte: got %0h expected nothing", got_q.pop_front());
            end else check("tx_byte", got_q.pop_front(), exp_bytes.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            repeat (2) @(negedge sysclk);
            rxc = 1'b1;
            repeat (4) @(negedge sysclk);
            rxc = 1'b0;
            repeat (2) @(negedge sysclk);
        end
    endtask

    task automatic send_frame(input logic [511:0] f);
        exp_work.push_back(f);
        frames++;
        for (int i = 0; i < WB; i++) send_byte(f[511-8*i -: 8]);
        repeat (4) @(negedge sysclk);
        check("work_valid_count", wv_seen, frames);
        check("rx_busy_after_commit", rx_busy, 0);
    endtask

    task automatic resync();
        rxtxr = 1'b1;
        repeat (4) @(negedge sysclk);
        rxtxr = 1'b0;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic push(input logic [31:0] w);
        result_data = w;
        result_push = 1'b1;
        @(negedge sysclk);
        result_push = 1'b0;
        if (model.size() < FD) begin
            model.push_back(w);
            for (int i = RB - 1; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
        end else if (drops < 255) drops++;
    endtask

    task automatic pulse_txc(output logic b);
        txc = 1'b1;
        repeat (5) @(negedge sysclk);
        b = txd;
        txc = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    task automatic read_byte(input bit last);
        logic b;
        logic [7:0] v;
        int n;
        b = 1'b0;
        n = 0;
        v = '0;
        while (b !== 1'b1 && n < 40) begin
            pulse_txc(b);
            n++;
        end
        if (b !== 1'b1) begin
            tests++; fails++;
            $display("FAIL marker_timeout: got txd %b after %0d polls expected 1", b, n);
        end
        for (int i = 0; i < 8; i++) begin
            if (last && i == 7) check("fifo_count_before_pop", fifo_count, model.size());
            pulse_txc(b);
            v[i] = b;
        end
        got_q.push_back(v);
        repeat (2) @(negedge sysclk);
    endtask

    task automatic read_word();
        for (int k = 0; k < RB; k++) read_byte(k == RB - 1);
        void'(model.pop_front());
        check("fifo_count_after_pop", fifo_count, model.size());
    endtask

    function automatic logic [511:0] rand_frame();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        logic b;
        logic [511:0] golden, partial;
        rst_n = 1'b0; rxd = 1'b0; rxc = 1'b0; rxtxr = 1'b0; txc = 1'b0;
        result_push = 1'b0; result_data = '0;
        repeat (3) @(negedge sysclk);
        check("reset_txd", txd, 0);
        check("reset_work_valid", work_valid, 0);
        check("reset_work_data", work_data, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_drop_count", drop_count, 0);
        check("reset_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sysclk);

        // work load with known midstate/data
        resync();
        golden = {256'h2b3f8126_0d6c1f4e_9a7b3c52_e81d4f60_7c2a9b31_5e8f0a4d_c3b71926_2619c0b5,
                  256'h00000000_00000000_00000000_80000000_00000000_39f3001b_6b7b8d4d_c14bfc31};
        send_frame(golden);
        check("work_msb_byte", work_data[511:504], 8'h2b);
        check("work_lsb_byte", work_data[7:0], 8'h31);
        check("work_pad_byte", work_data[159:152], 8'h80);

        // result readback
        push(32'h2966e1b9);
        check("fifo_count_one", fifo_count, 1);
        read_word();

        // idle polling
        for (int i = 0; i < 20; i++) begin
            pulse_txc(b);
            check("idle_txd", b, 0);
        end

        // overflow and saturation
        for (int i = 1; i <= 5; i++) push(32'(i));
        check("ovf_fifo_count", fifo_count, model.size());
        check("ovf_drop_count", drop_count, drops);
        for (int i = 0; i < 260; i++) push($urandom);
        check("sat_drop_count", drop_count, drops);
        check("sat_fifo_count", fifo_count, FD);
        for (int i = 0; i < FD; i++) read_word();

        // resync mid work frame
        partial = rand_frame();
        for (int i = 0; i < 3; i++) send_byte(partial[511-8*i -: 8]);
        check("rx_busy_partial", rx_busy, 1);
        resync();
        check("rx_busy_resync", rx_busy, 0);
        check("work_held_resync", work_data, golden);
        send_frame(rand_frame());

        // resync mid result readback
        push(32'h2966e1b9);
        read_byte(0);
        read_byte(0);
        resync();
        check("txd_after_resync", txd, 0);
        check("fifo_count_resync", fifo_count, model.size());
        check("drop_count_resync", drop_count, drops);
        exp_bytes.push_front(8'h66);
        exp_bytes.push_front(8'h29);
        read_word();

        // async reset during transmission
        push(32'hdeadbeef);
        read_byte(0);
        pulse_txc(b);
        check("marker_before_reset", b, 1);
        @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check("async_txd", txd, 0);
        check("async_fifo_count", fifo_count, 0);
        check("async_drop_count", drop_count, 0);
        #1 rst_n = 1'b1;
        model.delete();
        exp_bytes.delete();
        drops = 0;
        repeat (2) @(negedge sysclk);

        // randomized mix against the queue model
        send_frame(rand_frame());
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: push($urandom);
                2: if (model.size() > 0) read_word();
                   else begin
                       pulse_txc(b);
                       check("rand_idle_txd", b, 0);
                   end
                default: check("rand_drop_count", drop_count, drops);
            endcase
            check("rand_fifo_count", fifo_count, model.size());
        end
        check("rand_drop_final", drop_count, drops);
        while (model.size() > 0) read_word();
        send_frame(rand_frame());
        repeat (4) @(negedge sysclk);
        check("exp_bytes_drained", exp_bytes.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
